// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction
// memory and registers the fetched word plus its PC into the IF/ID register.
module fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h8B1F03FF
) (
  input  logic        CLK,
  input  logic        nReset,
  output logic [63:0] IMemAddress,
  input  logic [31:0] IMemInstruction,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [63:0] BranchTarget,
  input  logic        Halt,
  output logic [31:0] IFID_Instruction,
  output logic [63:0] IFID_PC,
  output logic        IFID_Valid,
  output logic [63:0] PC,
  output logic        Halted,
  output logic        Misaligned,
  output logic [31:0] FetchCount
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [63:0] ifid_pc_q, ifid_pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        halted_q, halted_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_valid_d  = ifid_valid_q;
    misaligned_d  = misaligned_q;
    fetch_count_d = fetch_count_q;

    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (BranchTaken) begin
          // Flush the wrong-path fetch; IFID_PC deliberately keeps its value.
          pc_d         = {BranchTarget[63:2], 2'b00};
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
          misaligned_d = misaligned_q | (BranchTarget[1:0] != 2'b00);
        end else if (Halt) begin
          state_d      = ST_HALT;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end else if (!Stall) begin
          ifid_instr_d  = IMemInstruction;
          ifid_pc_d     = pc_q;
          ifid_valid_d  = 1'b1;
          pc_d          = pc_q + 64'd4;
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_BOOT;
    endcase

    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge CLK) begin
    if (!nReset) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      ifid_instr_q  <= NOP_INSTR;
      ifid_pc_q     <= 64'h0;
      ifid_valid_q  <= 1'b0;
      halted_q      <= 1'b0;
      misaligned_q  <= 1'b0;
      fetch_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_valid_q  <= ifid_valid_d;
      halted_q      <= halted_d;
      misaligned_q  <= misaligned_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign IMemAddress      = pc_q;
  assign PC               = pc_q;
  assign IFID_Instruction = ifid_instr_q;
  assign IFID_PC          = ifid_pc_q;
  assign IFID_Valid       = ifid_valid_q;
  assign Halted           = halted_q;
  assign Misaligned       = misaligned_q;
  assign FetchCount       = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small combinational instruction memory.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h8B1F03FF;

  logic        CLK = 1'b0;
  logic        nReset;
  logic [63:0] IMemAddress;
  logic [31:0] IMemInstruction;
  logic        Stall;
  logic        BranchTaken;
  logic [63:0] BranchTarget;
  logic        Halt;
  logic [31:0] IFID_Instruction;
  logic [63:0] IFID_PC;
  logic        IFID_Valid;
  logic [63:0] PC;
  logic        Halted;
  logic        Misaligned;
  logic [31:0] FetchCount;

  logic [31:0] mem [0:127];
  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  assign IMemInstruction = mem[IMemAddress[8:2]];

  fetch_stage dut (
    .CLK(CLK), .nReset(nReset), .IMemAddress(IMemAddress),
    .IMemInstruction(IMemInstruction), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .Halt(Halt),
    .IFID_Instruction(IFID_Instruction), .IFID_PC(IFID_PC),
    .IFID_Valid(IFID_Valid), .PC(PC), .Halted(Halted),
    .Misaligned(Misaligned), .FetchCount(FetchCount)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [63:0] pc, input logic [63:0] ipc,
                           input logic [31:0] instr, input logic vld, input logic [31:0] cnt);
    chk({tag, ".PC"}, PC, pc);
    chk({tag, ".IMemAddress"}, IMemAddress, pc);
    chk({tag, ".IFID_PC"}, IFID_PC, ipc);
    chk({tag, ".IFID_Instruction"}, {32'h0, IFID_Instruction}, {32'h0, instr});
    chk({tag, ".IFID_Valid"}, {63'h0, IFID_Valid}, {63'h0, vld});
    chk({tag, ".FetchCount"}, {32'h0, FetchCount}, {32'h0, cnt});
    $display("step %s: PC=%h IFID_PC=%h instr=%h valid=%0b cnt=%0d halted=%0b mis=%0b",
             tag, PC, IFID_PC, IFID_Instruction, IFID_Valid, FetchCount, Halted, Misaligned);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hD5030000 | i;
    mem[0]  = 32'hF84083EA;  // 0x000
    mem[5]  = 32'hAA0B014A;  // 0x014
    mem[8]  = 32'h8A0A018C;  // 0x020
    mem[21] = 32'hF80203ED;  // 0x054

    nReset = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = 64'h0; Halt = 1'b0;
    step(); step();
    chk_state("reset", 64'h0, 64'h0, NOP, 1'b0, 32'd0);
    chk("reset.Halted", {63'h0, Halted}, 64'h0);
    chk("reset.Misaligned", {63'h0, Misaligned}, 64'h0);

    nReset = 1'b1;
    step();
    chk_state("boot", 64'h0, 64'h0, NOP, 1'b0, 32'd0);
    step();
    chk_state("fetch0", 64'h4, 64'h0, 32'hF84083EA, 1'b1, 32'd1);
    for (int i = 0; i < 5; i++) step();
    chk_state("fetch5", 64'h18, 64'h14, 32'hAA0B014A, 1'b1, 32'd6);
    step(); step();
    chk_state("fetch7", 64'h20, 64'h1C, mem[7], 1'b1, 32'd8);

    Stall = 1'b1;
    step(); step();
    chk_state("stall", 64'h20, 64'h1C, mem[7], 1'b1, 32'd8);
    Stall = 1'b0;
    step();
    chk_state("unstall", 64'h24, 64'h20, 32'h8A0A018C, 1'b1, 32'd9);

    Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 64'h54;
    step();
    chk_state("redirect", 64'h54, 64'h20, NOP, 1'b0, 32'd9);
    Stall = 1'b0; BranchTaken = 1'b0;
    step();
    chk_state("target", 64'h58, 64'h54, 32'hF80203ED, 1'b1, 32'd10);

    BranchTaken = 1'b1; BranchTarget = 64'h56;
    step();
    chk("misal.PC", PC, 64'h54);
    chk("misal.flag", {63'h0, Misaligned}, 64'h1);
    BranchTarget = 64'h0;
    step();
    chk("aligned.PC", PC, 64'h0);
    chk("aligned.flag", {63'h0, Misaligned}, 64'h1);
    BranchTarget = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    chk_state("to_top", 64'hFFFF_FFFF_FFFF_FFFC, 64'h54, NOP, 1'b0, 32'd10);
    BranchTaken = 1'b0;
    step();
    chk_state("wrap", 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, mem[127], 1'b1, 32'd11);

    Halt = 1'b1; BranchTaken = 1'b1; BranchTarget = 64'h64;
    step();
    chk("br_over_halt.PC", PC, 64'h64);
    chk("br_over_halt.Halted", {63'h0, Halted}, 64'h0);
    Halt = 1'b0; BranchTaken = 1'b0;
    step(); step();
    chk_state("pre_halt", 64'h6C, 64'h68, mem[26], 1'b1, 32'd13);

    Halt = 1'b1;
    step();
    chk_state("halt", 64'h6C, 64'h68, NOP, 1'b0, 32'd13);
    chk("halt.Halted", {63'h0, Halted}, 64'h1);
    Halt = 1'b0; BranchTaken = 1'b1; BranchTarget = 64'h100;
    step();
    chk_state("halt_br", 64'h6C, 64'h68, NOP, 1'b0, 32'd13);
    chk("halt_br.Halted", {63'h0, Halted}, 64'h1);
    BranchTaken = 1'b0;
    step();
    chk("halt_sticky.Halted", {63'h0, Halted}, 64'h1);

    nReset = 1'b0;
    step();
    chk_state("rst2", 64'h0, 64'h0, NOP, 1'b0, 32'd0);
    chk("rst2.Halted", {63'h0, Halted}, 64'h0);
    chk("rst2.Misaligned", {63'h0, Misaligned}, 64'h0);
    nReset = 1'b1;
    step();
    chk_state("boot2", 64'h0, 64'h0, NOP, 1'b0, 32'd0);
    step();
    chk_state("fetch0b", 64'h4, 64'h0, 32'hF84083EA, 1'b1, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch (IF) stage of the 5-stage ARMv8 pipeline. It sits directly upstream of the combinational instruction memory and owns the program counter. It drives the fetch address, captures the returned instruction word together with its PC into the IF/ID pipeline register, and handles stall, branch redirect/flush and halt.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.
NOP_INSTR, 32'h8B1F03FF, bubble encoding inserted on flush/halt/reset.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
nReset  in  1  synchronous, active-low reset; sampled on the rising CLK edge.
IMemAddress  out  64  fetch address; combinationally equal to PC.
IMemInstruction  in  32  instruction word returned combinationally by the instruction memory for IMemAddress.
Stall  in  1  hazard stall from the decode stage; holds PC and IF/ID.
BranchTaken  in  1  redirect request from the branch-resolution stage.
BranchTarget  in  64  redirect address; valid when BranchTaken=1.
Halt  in  1  end-of-program request; sticky until reset.
IFID_Instruction  out  32  registered instruction to decode.
IFID_PC  out  64  registered PC of IFID_Instruction.
IFID_Valid  out  1  1 = IFID_Instruction is a real fetched instruction; 0 = bubble.
PC  out  64  current program counter.
Halted  out  1  1 while in the HALT state.
Misaligned  out  1  sticky flag: a redirect target had bits [1:0] != 0.
FetchCount  out  32  number of valid instructions captured into IF/ID.

Behaviour:
- Reset (nReset=0 at a rising edge): PC=RESET_PC, IFID_Instruction=NOP_INSTR, IFID_PC=0, IFID_Valid=0, Halted=0, Misaligned=0, FetchCount=0, state=BOOT. Reset overrides every other input, including in the middle of a stall, redirect or halt.
- State machine: BOOT -> RUN -> HALT.
  - BOOT lasts exactly one cycle. PC is not advanced, IF/ID keeps the bubble, and the next state is RUN.
  - RUN -> HALT when Halt=1, unless BranchTaken=1 in the same cycle.
  - HALT is exited only by reset.
- IMemAddress=PC at all times, with zero latency. The memory is combinational, so the fetch latency is 1 cycle: the instruction at address A appears on IFID_* on the edge after PC=A.
- RUN priority per edge: BranchTaken > Halt > Stall > normal.
  - Normal: IF/ID <= {IMemInstruction, PC, Valid=1}; PC <= PC+4; FetchCount <= FetchCount+1.
  - Stall=1: PC, IF/ID and FetchCount hold.
  - BranchTaken=1:
    - PC <= {BranchTarget[63:2], 2'b00}.
    - IF/ID <= {NOP_INSTR, IFID_PC unchanged, Valid=0}; this is the flush of the wrong-path fetch.
    - FetchCount holds.
    - Misaligned <= Misaligned | (BranchTarget[1:0] != 0).
    - Redirect wins over Stall and over Halt in the same cycle.
  - Halt=1 (no redirect): PC holds; IF/ID <= {NOP_INSTR, Valid=0}; Halted <= 1.
- BranchTaken and Halt are ignored in BOOT and HALT.
- Arithmetic:
  - PC+4 is 64-bit and wraps modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC -> 0.
  - FetchCount wraps from 32'hFFFFFFFF to 0.
- All outputs are registered except IMemAddress. No X may propagate from IMemInstruction while IFID_Valid=0.

Test Plan:
- Reset: hold nReset=0 for 2 cycles, then release -> PC=0x0, IFID_Instruction=32'h8B1F03FF, IFID_Valid=0, FetchCount=0. After release: the BOOT cycle leaves PC=0x0; the next edge gives IFID_PC=0x0, IFID_Instruction=mem[0x000]=32'hF84083EA, PC=0x4.
- Sequential fetch over the test program for 6 edges after BOOT -> IFID_PC=0x014, IFID_Instruction=32'hAA0B014A, PC=0x018, FetchCount=6.
- Stall=1 for 2 cycles while PC=0x020 -> PC stays 0x020, IFID_PC stays 0x01C, FetchCount unchanged. After release, the next edge gives IFID_Instruction=32'h8A0A018C.
- Stall=1 and BranchTaken=1 with BranchTarget=0x054 in the same cycle -> PC=0x054, IFID_Valid=0, IFID_Instruction=NOP. The next edge gives IFID_PC=0x054, IFID_Instruction=32'hF80203ED, IFID_Valid=1.
- Misaligned redirect: BranchTarget=0x056 -> PC=0x054, Misaligned=1. Misaligned stays 1 after a later aligned redirect to 0x000 and clears only on reset.
- Halt=1 at PC=0x06C -> Halted=1, PC frozen at 0x06C, IFID_Valid=0. A later BranchTaken=1 is ignored. Asserting nReset=0 for one edge -> PC=0x0, Halted=0, state BOOT.
